// File: rtl/riscv_defs.sv
// Shared widths, load funct3 encodings and the load-queue entry layout
// for the writeback slice.
package riscv_defs;

  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [2:0]       funct3;
    logic [1:0]       addr_lo;
  } ld_entry_t;

endpackage

// File: rtl/riscv_wb_load_fmt.sv
// Combinational load data extractor: selects byte/half/word from an aligned
// memory word and applies sign or zero extension.
module riscv_wb_load_fmt
  import riscv_defs::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] value_o,
  output logic            illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(data_i >> {addr_lo_i, 3'b000});
  assign half_sel = 16'(data_i >> {addr_lo_i[1], 4'b0000});

  always_comb begin
    value_o   = data_i;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_LB:   value_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  value_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   value_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  value_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   value_o = data_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_writeback.sv
// Writeback stage: arbitrates ALU results and in-order load responses onto the
// single regfile write port and tracks outstanding loads for hazard detection.
module riscv_writeback
  import riscv_defs::*;
#(
  parameter int unsigned LD_DEPTH = 2,
  parameter int unsigned LD_PTR_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alu_valid_i,
  input  logic [REG_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]  alu_value_i,
  output logic             alu_ready_o,
  input  logic             ld_issue_i,
  input  logic [REG_W-1:0] ld_rd_i,
  input  logic [2:0]       ld_funct3_i,
  input  logic [1:0]       ld_addr_lo_i,
  output logic             ld_ready_o,
  input  logic             mem_rsp_valid_i,
  input  logic [XLEN-1:0]  mem_rsp_data_i,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]  wb_value_o,
  output logic [XLEN-1:0]  busy_mask_o,
  output logic             err_o
);

  localparam int unsigned CNT_W = LD_PTR_W + 1;

  ld_entry_t           q_mem [LD_DEPTH];
  logic [LD_PTR_W-1:0] rd_ptr_q;
  logic [LD_PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                wb_is_load_q;

  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  ld_entry_t           head;
  logic [XLEN-1:0]     fmt_value;
  logic                fmt_illegal;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(LD_DEPTH));
  assign push        = ld_issue_i && !full;
  assign pop         = mem_rsp_valid_i && !empty;
  assign ld_ready_o  = !full;
  // Memory cannot be stalled, so a load response always takes the write port.
  assign alu_ready_o = !pop;
  assign head        = q_mem[rd_ptr_q];

  riscv_wb_load_fmt u_load_fmt (
    .funct3_i  (head.funct3),
    .addr_lo_i (head.addr_lo),
    .data_i    (mem_rsp_data_i),
    .value_o   (fmt_value),
    .illegal_o (fmt_illegal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wb_rd_o      <= '0;
      wb_value_o   <= '0;
      wb_is_load_q <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + LD_PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LD_PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);

      if (pop) begin
        wb_rd_o      <= head.rd;
        wb_value_o   <= fmt_value;
        wb_is_load_q <= 1'b1;
      end else if (alu_valid_i) begin
        wb_rd_o      <= alu_rd_i;
        wb_value_o   <= alu_value_i;
        wb_is_load_q <= 1'b0;
      end else begin
        wb_rd_o      <= '0;
        wb_is_load_q <= 1'b0;
      end

      if ((ld_issue_i && full) || (mem_rsp_valid_i && empty) || (pop && fmt_illegal))
        err_o <= 1'b1;
    end
  end

  // Queue payload storage needs no reset; validity comes from count_q.
  always_ff @(posedge clk_i) begin
    if (push) q_mem[wr_ptr_q] <= '{rd: ld_rd_i, funct3: ld_funct3_i, addr_lo: ld_addr_lo_i};
  end

  // Entry i is live when its distance from the read pointer is below count.
  always_comb begin
    logic [LD_PTR_W-1:0] off;
    busy_mask_o = '0;
    off         = '0;
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      off = LD_PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(off) < count_q) busy_mask_o[q_mem[i].rd] = 1'b1;
    end
    if (wb_is_load_q) busy_mask_o[wb_rd_o] = 1'b1;
    busy_mask_o[0] = 1'b0;
  end

endmodule
